// File: rtl/renode_ahb_burst_sequencer.sv
// AHB manager address-phase sequencer for the Renode co-simulation manager.
// Takes one burst command and issues it beat by beat on HADDR/HTRANS/HBURST/
// HSIZE/HWRITE. It tracks the pipelined data phases, inserts BUSY while hold is
// high, and aborts the burst on an ERROR response. Data moves elsewhere, keyed
// off beat_done/beat_index. LengthWidth must be at least 5 so 16-beat bursts fit.
module renode_ahb_burst_sequencer #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int LengthWidth  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AddressWidth-1:0] cmd_addr,
    input  logic [2:0]              cmd_burst,
    input  logic [2:0]              cmd_size,
    input  logic                    cmd_write,
    input  logic [LengthWidth-1:0]  cmd_length,
    input  logic                    hold,
    output logic [AddressWidth-1:0] haddr,
    output logic [1:0]              htrans,
    output logic [2:0]              hburst,
    output logic [2:0]              hsize,
    output logic                    hwrite,
    input  logic                    hready,
    input  logic                    hresp,
    output logic                    beat_done,
    output logic [LengthWidth-1:0]  beat_index,
    output logic                    done,
    output logic                    error
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StLast = 2'd2;
    localparam logic [1:0] StErr  = 2'd3;

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransBusy   = 2'd1;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;

    localparam logic [2:0] BurstSingle = 3'd0;
    localparam logic [2:0] BurstIncr   = 3'd1;
    localparam logic [2:0] BurstWrap4  = 3'd2;
    localparam logic [2:0] BurstIncr4  = 3'd3;
    localparam logic [2:0] BurstWrap8  = 3'd4;
    localparam logic [2:0] BurstIncr8  = 3'd5;
    localparam logic [2:0] BurstWrap16 = 3'd6;
    localparam logic [2:0] BurstIncr16 = 3'd7;

    logic [1:0]              state;
    logic [AddressWidth-1:0] step;
    logic [AddressWidth-1:0] wrap_mask;    // all ones for incrementing bursts
    logic [LengthWidth-1:0]  beats_total;
    logic [LengthWidth-1:0]  addr_count;   // address phases completed so far
    logic [LengthWidth-1:0]  data_index;   // beat owning the pending data phase
    logic                    data_pending;

    logic [LengthWidth-1:0]  cmd_beats;
    logic [AddressWidth-1:0] cmd_step;
    logic [AddressWidth-1:0] cmd_mask;
    logic [AddressWidth-1:0] span_base;
    logic [31:0]             span;
    logic                    is_wrap;
    logic                    reject;
    logic [AddressWidth-1:0] next_addr;
    logic                    last_addr;
    logic [1:0]              next_type;
    logic [1:0]              resume_type;

    assign cmd_ready = (state == StIdle);

    // Decode the offered command: beat count, step, wrap mask, legality.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        cmd_beats = LengthWidth'(1);
        case (cmd_burst)
            BurstIncr:              cmd_beats = (cmd_length == '0) ? LengthWidth'(1) : cmd_length;
            BurstWrap4, BurstIncr4:   cmd_beats = LengthWidth'(4);
            BurstWrap8, BurstIncr8:   cmd_beats = LengthWidth'(8);
            BurstWrap16, BurstIncr16: cmd_beats = LengthWidth'(16);
            default:                cmd_beats = LengthWidth'(1);
        endcase
        is_wrap   = (cmd_burst == BurstWrap4) || (cmd_burst == BurstWrap8) ||
                    (cmd_burst == BurstWrap16);
        cmd_step  = AddressWidth'(1) << cmd_size;
        span      = 32'(cmd_beats) << cmd_size;
        cmd_mask  = is_wrap ? (AddressWidth'(span) - AddressWidth'(1)) : '1;
        span_base = is_wrap ? (cmd_addr & ~cmd_mask) : cmd_addr;
        reject    = ((cmd_addr & (cmd_step - AddressWidth'(1))) != '0) ||
                    ((32'd8 << cmd_size) > 32'(DataWidth)) ||
                    ((cmd_burst != BurstIncr) &&
                     ((32'(span_base[9:0]) + span) > 32'd1024));
    end

    // Next beat address and transfer type for the burst in flight.
    always_comb begin
        next_addr   = (haddr & ~wrap_mask) | ((haddr + step) & wrap_mask);
        last_addr   = (addr_count == (beats_total - LengthWidth'(1)));
        next_type   = ((hburst == BurstIncr) && (next_addr[9:0] == '0)) ? TransNonseq : TransSeq;
        resume_type = ((hburst == BurstIncr) && (haddr[9:0] == '0)) ? TransNonseq : TransSeq;
    end

    // Burst state machine, registered bus outputs and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            haddr        <= '0;
            htrans       <= TransIdle;
            hburst       <= BurstSingle;
            hsize        <= 3'd0;
            hwrite       <= 1'b0;
            step         <= '0;
            wrap_mask    <= '0;
            beats_total  <= '0;
            addr_count   <= '0;
            data_index   <= '0;
            data_pending <= 1'b0;
            beat_done    <= 1'b0;
            beat_index   <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the pulses default low
            // here and later assignments in the same edge override them.
            beat_done <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        if (reject) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            haddr        <= cmd_addr;
                            htrans       <= TransNonseq;
                            hburst       <= cmd_burst;
                            hsize        <= cmd_size;
                            hwrite       <= cmd_write;
                            step         <= cmd_step;
                            wrap_mask    <= cmd_mask;
                            beats_total  <= cmd_beats;
                            addr_count   <= '0;
                            data_pending <= 1'b0;
                            state        <= StAddr;
                        end
                    end
                end
                StAddr, StLast: begin
                    if (data_pending && hresp) begin
                        // First ERROR cycle cancels the pending address at once.
                        htrans <= TransIdle;
                        if (hready) begin
                            done         <= 1'b1;
                            error        <= 1'b1;
                            data_pending <= 1'b0;
                            state        <= StIdle;
                        end else begin
                            state <= StErr;
                        end
                    end else if (hready) begin
                        if (data_pending) begin
                            beat_done  <= 1'b1;
                            beat_index <= data_index;
                        end
                        data_pending <= 1'b0;
                        if (state == StLast) begin
                            done  <= 1'b1;
                            state <= StIdle;
                        end else if (htrans[1]) begin
                            data_pending <= 1'b1;
                            data_index   <= addr_count;
                            addr_count   <= addr_count + LengthWidth'(1);
                            if (last_addr) begin
                                htrans <= TransIdle;
                                state  <= StLast;
                            end else begin
                                haddr  <= next_addr;
                                htrans <= hold ? TransBusy : next_type;
                            end
                        end else if (htrans == TransBusy && !hold) begin
                            htrans <= resume_type;
                        end
                    end
                end
                StErr: begin
                    if (hready) begin
                        done         <= 1'b1;
                        error        <= 1'b1;
                        data_pending <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_renode_ahb_burst_sequencer.sv
// Directed bench for renode_ahb_burst_sequencer: each burst is issued, every
// non-idle bus cycle is logged, and the log, beat pulses, completion latency and
// error flag are compared against hand-computed expectations.
module tb_renode_ahb_burst_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    localparam logic [1:0] NS  = 2'd2;
    localparam logic [1:0] SQ  = 2'd3;
    localparam logic [1:0] BSY = 2'd1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_burst;
    logic [2:0]    cmd_size;
    logic          cmd_write;
    logic [LW-1:0] cmd_length;
    logic          hold;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic [2:0]    hsize;
    logic          hwrite;
    logic          hready;
    logic          hresp;
    logic          beat_done;
    logic [LW-1:0] beat_index;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    renode_ahb_burst_sequencer #(
        .AddressWidth(AW),
        .DataWidth   (DW),
        .LengthWidth (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .cmd_size  (cmd_size),
        .cmd_write (cmd_write),
        .cmd_length(cmd_length),
        .hold      (hold),
        .haddr     (haddr),
        .htrans    (htrans),
        .hburst    (hburst),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hready    (hready),
        .hresp     (hresp),
        .beat_done (beat_done),
        .beat_index(beat_index),
        .done      (done),
        .error     (error)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0]  log_trans[$];
    logic [31:0] log_addr[$];
    logic [1:0]  exp_trans[$];
    logic [31:0] exp_addr[$];
    logic [2:0]  first_burst;
    logic [2:0]  first_size;
    logic        first_write;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer a command in the current cycle; returns at the negedge of cycle T+1.
    task automatic send_cmd(input string tag, input logic [2:0] burst, input logic [2:0] size,
                            input logic write, input logic [31:0] addr, input logic [7:0] len);
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_burst  = burst;
        cmd_size   = size;
        cmd_write  = write;
        cmd_addr   = addr;
        cmd_length = len;
        hready     = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Drive the bus side cycle by cycle until done, logging non-idle cycles.
    task automatic run_burst(input string tag, input int err_beat, input int hold_beat,
                             input logic [31:0] wait_addr, input int wait_n,
                             output int lat, output int nbeats, output logic err_seen,
                             output logic finished);
        int   dp_beat   = -1;
        int   issued    = 0;
        int   hold_left = 0;
        int   err_st    = 0;
        int   waits     = wait_n;
        logic hr;
        lat = 0; nbeats = 0; err_seen = 1'b0; finished = 1'b0;
        log_trans.delete();
        log_addr.delete();
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (beat_done) begin
                check({tag, " beat_index"}, 32'(beat_index), nbeats);
                nbeats++;
            end
            if (done) begin
                lat      = cyc;
                err_seen = error;
                finished = 1'b1;
                hold     = 1'b0;
                hresp    = 1'b0;
                hready   = 1'b1;
                return;
            end
            if (htrans != 2'd0) begin
                if (log_trans.size() == 0) begin
                    first_burst = hburst;
                    first_size  = hsize;
                    first_write = hwrite;
                end
                log_trans.push_back(htrans);
                log_addr.push_back(haddr);
            end
            hr    = 1'b1;
            hresp = 1'b0;
            if (err_st == 1) begin
                hresp  = 1'b1;
                err_st = 2;
            end else if (err_st == 0 && dp_beat == err_beat) begin
                hresp  = 1'b1;
                hr     = 1'b0;
                err_st = 1;
            end else if (waits > 0 && htrans[1] && haddr == wait_addr) begin
                hr = 1'b0;
                waits--;
            end
            hready = hr;
            if (hold_left > 0) begin
                hold = 1'b1;
                hold_left--;
            end else begin
                hold = 1'b0;
            end
            if (hr && htrans[1]) begin
                if (issued == hold_beat) begin
                    hold      = 1'b1;
                    hold_left = 1;
                end
                dp_beat = issued;
                issued++;
            end else if (hr) begin
                dp_beat = -1;
            end
            @(negedge clk);
        end
        hold   = 1'b0;
        hresp  = 1'b0;
        hready = 1'b1;
    endtask

    task automatic do_test(input string tag, input logic [2:0] burst, input logic [2:0] size,
                           input logic write, input logic [31:0] addr, input logic [7:0] len,
                           input int err_beat, input int hold_beat,
                           input logic [31:0] wait_addr, input int wait_n,
                           input int exp_lat, input int exp_beats, input logic exp_err);
        int   lat;
        int   nbeats;
        logic err_seen;
        logic finished;
        send_cmd(tag, burst, size, write, addr, len);
        run_burst(tag, err_beat, hold_beat, wait_addr, wait_n, lat, nbeats, err_seen, finished);
        check({tag, " finished"}, 32'(finished), 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " beats"}, nbeats, exp_beats);
        check({tag, " error"}, 32'(err_seen), 32'(exp_err));
        check({tag, " ready_at_done"}, 32'(cmd_ready), 32'd1);
        check({tag, " log_len"}, log_trans.size(), exp_trans.size());
        for (int i = 0; i < exp_trans.size() && i < log_trans.size(); i++) begin
            check($sformatf("%s htrans[%0d]", tag, i), 32'(log_trans[i]), 32'(exp_trans[i]));
            check($sformatf("%s haddr[%0d]", tag, i), log_addr[i], exp_addr[i]);
        end
        if (log_trans.size() > 0) begin
            check({tag, " hburst"}, 32'(first_burst), 32'(burst));
            check({tag, " hsize"}, 32'(first_size), 32'(size));
            check({tag, " hwrite"}, 32'(first_write), 32'(write));
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_burst  = 3'd0;
        cmd_size   = 3'd0;
        cmd_write  = 1'b0;
        cmd_length = '0;
        hold       = 1'b0;
        hready     = 1'b1;
        hresp      = 1'b0;
        #12;
        check("reset haddr", haddr, 32'h0);
        check("reset htrans", 32'(htrans), 32'd0);
        check("reset hburst", 32'(hburst), 32'd0);
        check("reset hsize", 32'(hsize), 32'd0);
        check("reset hwrite", 32'(hwrite), 32'd0);
        check("reset beat_done", 32'(beat_done), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Wrapping4 word read at 0x38 wraps within the 16-byte block.
        exp_trans = '{NS, SQ, SQ, SQ};
        exp_addr  = '{32'h38, 32'h3C, 32'h30, 32'h34};
        do_test("wrap4", 3'd2, 3'd2, 1'b0, 32'h38, 8'd0, 99, 99, 32'hFFFF_FFFF, 0, 6, 4, 1'b0);

        // Incrementing8 halfword write, two wait states on beat 2 (back-to-back accept).
        exp_trans = '{NS, SQ, SQ, SQ, SQ, SQ, SQ, SQ, SQ, SQ};
        exp_addr  = '{32'h100, 32'h102, 32'h104, 32'h104, 32'h104,
                      32'h106, 32'h108, 32'h10A, 32'h10C, 32'h10E};
        do_test("incr8", 3'd5, 3'd1, 1'b1, 32'h100, 8'd0, 99, 99, 32'h104, 2, 12, 8, 1'b0);

        // Undefined-length Incrementing across a 1 KB boundary restarts with NONSEQ.
        exp_trans = '{NS, NS, SQ};
        exp_addr  = '{32'h3FC, 32'h400, 32'h404};
        do_test("incr_1k", 3'd1, 3'd2, 1'b0, 32'h3FC, 8'd3, 99, 99, 32'hFFFF_FFFF, 0, 5, 3, 1'b0);

        // Incrementing4 word with hold after beat 0: two BUSY cycles at the next address.
        exp_trans = '{NS, BSY, BSY, SQ, SQ, SQ};
        exp_addr  = '{32'h20, 32'h24, 32'h24, 32'h24, 32'h28, 32'h2C};
        do_test("busy", 3'd3, 3'd2, 1'b1, 32'h20, 8'd0, 99, 0, 32'hFFFF_FFFF, 0, 8, 4, 1'b0);

        // Two-cycle ERROR on beat 1 data phase cancels the burst.
        exp_trans = '{NS, SQ, SQ};
        exp_addr  = '{32'h40, 32'h44, 32'h48};
        do_test("error", 3'd3, 3'd2, 1'b0, 32'h40, 8'd0, 1, 99, 32'hFFFF_FFFF, 0, 5, 1, 1'b1);

        // Rejected commands: misaligned word, and Incrementing16 crossing 1 KB.
        exp_trans.delete();
        exp_addr.delete();
        do_test("misaligned", 3'd0, 3'd2, 1'b0, 32'h42, 8'd0, 99, 99, 32'hFFFF_FFFF, 0, 1, 0, 1'b1);
        do_test("cross_1k", 3'd7, 3'd2, 1'b0, 32'h3F0, 8'd0, 99, 99, 32'hFFFF_FFFF, 0, 1, 0, 1'b1);

        // Reset asserted in the middle of an Incrementing16 burst.
        send_cmd("midreset", 3'd7, 3'd2, 1'b0, 32'h0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        check("midreset active", 32'(htrans), 32'(SQ));
        rst = 1'b1;
        #1;
        check("midreset htrans", 32'(htrans), 32'd0);
        check("midreset cmd_ready", 32'(cmd_ready), 32'd1);
        check("midreset haddr", haddr, 32'h0);
        check("midreset beat_done", 32'(beat_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single word read after reset recovery.
        exp_trans = '{NS};
        exp_addr  = '{32'h10};
        do_test("single", 3'd0, 3'd2, 1'b0, 32'h10, 8'd0, 99, 99, 32'hFFFF_FFFF, 0, 3, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/renode_ahb_burst_sequencer.md
Name: renode_ahb_burst_sequencer

Overview:
- AHB manager-side address-phase engine for the Renode co-simulation manager.
- Accepts one burst command, then drives HADDR/HTRANS/HBURST/HSIZE/HWRITE beat by beat.
- Tracks the pipelined data phases, inserts BUSY on request and aborts on ERROR.
- Sits between the Renode transaction decoder and the AHB bus; the data path is handled elsewhere and keyed off beat_done/beat_index.

Parameters:
AddressWidth, 32, width of cmd_addr/haddr
DataWidth, 32, bus data width; transfers with (8<<cmd_size) > DataWidth are rejected
LengthWidth, 8, width of cmd_length (beat count for undefined-length Incrementing bursts)

Ports:
clk  input  1  bus clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
cmd_addr  input  AddressWidth  first beat address
cmd_burst  input  3  burst_e encoding
cmd_size  input  3  transfer_size_e encoding
cmd_write  input  1  transfer_direction_e
cmd_length  input  LengthWidth  beats for Incrementing; 0 treated as 1; ignored otherwise
hold  input  1  request BUSY insertion between beats
haddr  output  AddressWidth  bus address
htrans  output  2  transfer_type_e
hburst  output  3  burst_e
hsize  output  3  transfer_size_e
hwrite  output  1  direction
hready  input  1  bus ready
hresp  input  1  response_e
beat_done  output  1  one-cycle pulse: a data phase completed OKAY
beat_index  output  LengthWidth  index of the completed beat, 0-based
done  output  1  one-cycle pulse: command finished (success or error)
error  output  1  qualifies done: 1 = ERROR response or rejected command

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - haddr=0, htrans=Idle, hburst=Single, hsize=Byte8bit, hwrite=Read.
  - beat_done=0, done=0, error=0, cmd_ready=1.
  - Any burst in flight is abandoned silently.
- States: IDLE, ADDR (address phases outstanding), LAST (final data phase only), ERR (second ERROR cycle pending).
- All bus outputs are registered and advance only on edges where hready=1, except the ERROR cancel below.
- cmd_ready=1 only in IDLE.
- Acceptance at edge T:
  - Beat count: Single=1, Wrapping4/Incrementing4=4, Wrapping8/Incrementing8=8, Wrapping16/Incrementing16=16, Incrementing=max(cmd_length,1).
  - Rejected with no bus activity (done=1, error=1 in cycle T+1, stay IDLE) if:
    - cmd_addr is not aligned to 1<<cmd_size;
    - size exceeds DataWidth;
    - a fixed-length burst crosses a 1 KB boundary.
  - Otherwise cycle T+1 drives NONSEQ at cmd_addr and enters ADDR.
- Address step bytes = 1<<cmd_size.
  - Incrementing types: next = addr + bytes, modulo 2^AddressWidth.
  - Wrapping types: boundary = beats*bytes; next = (addr & ~(boundary-1)) | ((addr+bytes) & (boundary-1)).
- Undefined-length Incrementing: a beat whose address is 1 KB aligned (other than the first beat) is issued as NONSEQ with hburst=Incrementing.
- Beat progression:
  - An address phase completes on an edge with hready=1 and htrans in {NONSEQ, SEQ}.
  - The next cycle drives the next beat as SEQ, or BUSY when hold=1.
  - BUSY carries the next beat's address and holds while hold=1; it is never issued before the first beat or after the last.
  - After the last address phase completes: htrans=Idle, enter LAST.
- Data phases:
  - A beat's data phase completes on the first hready=1 edge after its address phase; beat_done pulses the following cycle with beat_index.
  - The last OKAY data phase also pulses done=1, error=0 in the same cycle; return to IDLE, cmd_ready=1.
  - A back-to-back command may be accepted in that same IDLE cycle.
- ERROR response:
  - hresp=1 && hready=0 during a data phase: next edge forces htrans=Idle, cancelling the pending address, and enters ERR.
  - On hresp=1 && hready=1: pulse done=1, error=1, no beat_done for that beat, go to IDLE.
- Simultaneous hold=1 with the last address phase completing: hold is ignored; htrans=Idle.

Test Plan:
- Wrapping4, Word32bit, read, addr 0x38, hready=1 -> haddr 0x38,0x3C,0x30,0x34; htrans NONSEQ,SEQ,SEQ,SEQ; beat_done idx 0..3; done with error=0.
- Incrementing8, Halfword16bit, write, addr 0x100, hready low 2 cycles on beat 2 -> addresses 0x100..0x10E step 2 held stable during waits; 8 beat_done pulses; done error=0.
- Incrementing, Word32bit, cmd_length=3, addr 0x3FC -> 0x3FC NONSEQ, 0x400 NONSEQ, 0x404 SEQ; done after 3 beats.
- Incrementing4, word, addr 0x20, hold=1 for 2 cycles after beat 0 -> BUSY,BUSY at 0x24, then SEQ 0x24,0x28,0x2C.
- Incrementing4, word, addr 0x40, hresp=1/hready=0 on beat 1 data phase then hresp=1/hready=1 -> htrans Idle next cycle; done=1, error=1; beat_done only idx 0.
- Misaligned Word32bit addr 0x42, and Incrementing16 word at 0x3F0 -> htrans stays Idle; done=1, error=1 one cycle after acceptance; reset asserted mid-burst -> htrans=Idle, cmd_ready=1 immediately.
